// File: rtl/rst_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rst_sequencer
// Brief    : Staged reset-release controller; releases NUM_OUTS domain resets
//            in ascending order with HOLD_CYCLES edges between releases.
//            Optional macro WAIT_ACK_EN: per-stage ack handshake with timeout.
// Revision : 1.0 - initial release
// ============================================================================
module rst_sequencer #(
  parameter int NUM_OUTS       = 3,
  parameter int HOLD_CYCLES    = 16,
  parameter int CNT_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                SW_RST_REQ,
  input  logic [NUM_OUTS-1:0] STAGE_ACK,
  output logic [NUM_OUTS-1:0] STAGE_RST,
  output logic                SEQ_BUSY,
  output logic                SEQ_DONE,
  output logic                ERR
);

  localparam int                   c_idx_w     = (NUM_OUTS > 1) ? $clog2(NUM_OUTS) : 1;
  localparam logic [c_idx_w-1:0]   c_last_idx  = c_idx_w'(NUM_OUTS - 1);
  localparam logic [CNT_WIDTH-1:0] c_hold_last = CNT_WIDTH'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_HOLD     = 2'd0,
    S_WAIT_ACK = 2'd1,
    S_DONE     = 2'd2
  } state_t;

  state_t              r_state;
  logic [c_idx_w-1:0]  r_idx;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [NUM_OUTS-1:0] r_stage_rst;
  logic                r_busy;
  logic                r_done;

`ifdef WAIT_ACK_EN
  // Timeout fires on the edge that would bring the wait count to TIMEOUT_CYCLES.
  localparam logic [CNT_WIDTH-1:0] c_timeout_last = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  logic r_err;
`else
  logic w_unused_ack;
  assign w_unused_ack = ^STAGE_ACK;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= S_HOLD;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_stage_rst <= '1;
      r_busy      <= 1'b1;
      r_done      <= 1'b0;
`ifdef WAIT_ACK_EN
      r_err       <= 1'b0;
`endif
    end else if (SW_RST_REQ) begin
      r_state     <= S_HOLD;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_stage_rst <= '1;
      r_busy      <= 1'b1;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_HOLD: begin
          if (r_cnt == c_hold_last) begin
            r_stage_rst[r_idx] <= 1'b0;
            r_cnt              <= '0;
`ifdef WAIT_ACK_EN
            r_state            <= S_WAIT_ACK;
`else
            if (r_idx == c_last_idx) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`ifdef WAIT_ACK_EN
        S_WAIT_ACK: begin
          if (STAGE_ACK[r_idx]) begin
            r_cnt <= '0;
            if (r_idx == c_last_idx) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_HOLD;
              r_idx   <= r_idx + 1'b1;
            end
          end else if (r_cnt == c_timeout_last) begin
            // Ack never came: flag it and restart the whole sequence.
            r_err       <= 1'b1;
            r_state     <= S_HOLD;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_stage_rst <= '1;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif
        S_DONE: begin
          r_stage_rst <= '0;
        end
        default: begin
          r_state <= S_HOLD;
        end
      endcase
    end
  end

  assign STAGE_RST = r_stage_rst;
  assign SEQ_BUSY  = r_busy;
  assign SEQ_DONE  = r_done;
`ifdef WAIT_ACK_EN
  assign ERR       = r_err;
`else
  assign ERR       = 1'b0;
`endif

endmodule
`default_nettype wire
